// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V control path.
// Covers the opcodes, ALU control codes, ALUOp classes and controller states.
package riscv_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // The ALU decodes these same codes, so the values are fixed.
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_JAL,
    S_BEQ,
    S_TRAP
  } ctrl_state_e;

endpackage

// File: rtl/alu_decoder.sv
// Maps the ALUOp class and instruction funct fields to an ALU operation.
// funct_illegal depends only on funct3, so the FSM can consult it while still in DECODE.
module alu_decoder
  import riscv_pkg::*;
(
  input  alu_op_e     aluop,
  input  logic [2:0]  funct3,
  input  logic        op5,
  input  logic        funct7b5,
  output alu_ctrl_e   alu_control,
  output logic        funct_illegal
);

  always_comb begin
    funct_illegal = !(funct3 inside {3'b000, 3'b010, 3'b110, 3'b111});
    alu_control   = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        // Only R-type sub sets bit 5 of both op and funct7; addi ignores funct7.
        case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RISC-V datapath.
// Instruction and data accesses share one memory and wait on MemReady.
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       Illegal
);

  ctrl_state_e state, dstate, decode_target;
  alu_op_e     aluop;
  alu_ctrl_e   alu_control;
  logic        funct_illegal, pcupdate, branch;
  logic        unused_xlen;

  assign unused_xlen = (XLEN != 0);

  alu_decoder u_alu_decoder (
    .aluop         (aluop),
    .funct3        (funct3),
    .op5           (op[5]),
    .funct7b5      (funct7b5),
    .alu_control   (alu_control),
    .funct_illegal (funct_illegal)
  );

  assign ALUControl = alu_control;

  always_comb begin
    case (op)
      OP_LW, OP_SW: decode_target = S_MEMADR;
      OP_R:         decode_target = funct_illegal ? S_TRAP : S_EXECUTER;
      OP_I:         decode_target = funct_illegal ? S_TRAP : S_EXECUTEI;
      OP_JAL:       decode_target = S_JAL;
      OP_BEQ:       decode_target = S_BEQ;
      default:      decode_target = S_TRAP;
    endcase
  end

  // Unknown state encodings fall through to FETCH on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      Illegal <= 1'b0;
    end else begin
      case (state)
        S_FETCH:    if (MemReady) state <= S_DECODE;
        S_DECODE: begin
          state <= decode_target;
          if (decode_target == S_TRAP) Illegal <= 1'b1;
        end
        S_MEMADR:   state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (MemReady) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (MemReady) state <= S_FETCH;
        S_EXECUTER: state <= S_ALUWB;
        S_EXECUTEI: state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        S_BEQ:      state <= S_FETCH;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // While reset is held the datapath sees FETCH selects with every write enable low.
  assign dstate = reset ? S_FETCH : state;

  always_comb begin
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    aluop     = ALUOP_ADD;
    pcupdate  = 1'b0;
    branch    = 1'b0;
    case (dstate)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        pcupdate  = MemReady;
      end
      S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; end
      S_MEMWRITE: begin AdrSrc = 1'b1; MemWrite = 1'b1; end
      S_EXECUTER: begin ALUSrcA = 2'b10; aluop = ALUOP_FUNCT; end
      S_EXECUTEI: begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; aluop = ALUOP_FUNCT; end
      S_ALUWB:    RegWrite = 1'b1;
      S_JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pcupdate = 1'b1; end
      S_BEQ:      begin ALUSrcA = 2'b10; aluop = ALUOP_SUB; branch = 1'b1; end
      default:    ;
    endcase
    if (reset) begin
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      pcupdate = 1'b0;
      branch   = 1'b0;
    end
  end

  assign PCWrite = pcupdate | (branch & Zero);

  always_comb begin
    case (op)
      OP_LW, OP_I: ImmSrc = 2'b00;
      OP_SW:       ImmSrc = 2'b01;
      OP_BEQ:      ImmSrc = 2'b10;
      OP_JAL:      ImmSrc = 2'b11;
      default:     ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus randomized
// instruction streams checked against a per-instruction timing/effect model.
module tb_multicycle_controller;
  import riscv_pkg::*;

  logic       clk, reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int irw_cnt; int irw_cycle; int pcw_cnt; int rw_cnt; int rw_cycle;
    int mw_cnt; int mw_noadr; int alu_exec; int pcw_exec;
    int rs_last; int rs_after; int early_fetch; int imm_bad;
  } obs_t;

  multicycle_controller #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .ALUControl(ALUControl), .Illegal(Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_len(logic [6:0] o, int fw, int mw);
    if (o == OP_BEQ) return 3 + fw;
    if (o == OP_LW)  return 5 + fw + mw;
    if (o == OP_SW)  return 4 + fw + mw;
    return 4 + fw;
  endfunction

  function automatic int model_imm(logic [6:0] o);
    if (o == OP_SW)  return 1;
    if (o == OP_BEQ) return 2;
    if (o == OP_JAL) return 3;
    return 0;
  endfunction

  // ALU operation seen in the third non-wait cycle (execute / address / branch / jal).
  function automatic int model_alu(logic [6:0] o, logic [2:0] f3, logic f7);
    if (o == OP_BEQ) return 1;
    if (o != OP_R && o != OP_I) return 0;
    case (f3)
      3'b000:  return (o == OP_R && f7) ? 1 : 0;
      3'b010:  return 4;
      3'b110:  return 3;
      3'b111:  return 2;
      default: return 0;
    endcase
  endfunction

  // Drives one instruction for its expected length plus one FETCH-hold cycle and records what was seen.
  // fw = MemReady-low cycles in fetch, mw = MemReady-low cycles in the data access.
  task automatic run_instr(input logic [6:0] iop, input logic [2:0] if3, input logic if7,
                           input int fw, input int mw, input logic zb, output obs_t o);
    int  len;
    logic is_mem;
    len    = model_len(iop, fw, mw);
    is_mem = (iop == OP_LW) || (iop == OP_SW);
    o = '{default: 0};
    for (int c = 1; c <= len + 1; c++) begin
      op = iop; funct3 = if3; funct7b5 = if7;
      Zero = 1'($urandom_range(0, 1));
      if (c == fw + 3 && iop == OP_BEQ) Zero = zb;
      if (c <= fw)                                    MemReady = 1'b0;
      else if (c == fw + 1)                           MemReady = 1'b1;
      else if (c == len + 1)                          MemReady = 1'b0;
      else if (is_mem && c >= fw + 4 && c <= fw + 3 + mw) MemReady = 1'b0;
      else if (is_mem && c == fw + 4 + mw)            MemReady = 1'b1;
      else                                            MemReady = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (IRWrite)  begin o.irw_cnt++; o.irw_cycle = c; end
      if (PCWrite)  o.pcw_cnt++;
      if (RegWrite) begin o.rw_cnt++; o.rw_cycle = c; end
      if (MemWrite) begin o.mw_cnt++; if (!AdrSrc) o.mw_noadr++; end
      if (c == fw + 3) begin o.alu_exec = int'(ALUControl); o.pcw_exec = int'(PCWrite); end
      if (c == len)     o.rs_last  = int'(ResultSrc);
      if (c == len + 1) o.rs_after = int'(ResultSrc);
      if (c >= fw + 2 && c <= len && ResultSrc == 2'b10) o.early_fetch++;
      if (int'(ImmSrc) != model_imm(iop)) o.imm_bad++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; MemReady = 1'b1; op = OP_SW; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    tests++; if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b0000) begin fails++;
      $display("[TB] FAIL reset_enables got %b want 0000", {PCWrite, MemWrite, IRWrite, RegWrite}); end
    tests++; if (Illegal !== 1'b0) begin fails++; $display("[TB] FAIL reset_illegal got %b want 0", Illegal); end
    tests++; if (ResultSrc !== 2'b10 || ALUSrcB !== 2'b10 || AdrSrc !== 1'b0) begin fails++;
      $display("[TB] FAIL reset_selects got rs=%b srcb=%b adr=%b want 10 10 0", ResultSrc, ALUSrcB, AdrSrc); end
    @(posedge clk); #1;
    reset = 1'b0; MemReady = 1'b0;
    @(negedge clk);
    tests++; if (ResultSrc !== 2'b10 || IRWrite !== 1'b0 || PCWrite !== 1'b0) begin fails++;
      $display("[TB] FAIL post_reset_fetch got rs=%b irw=%b pcw=%b want 10 0 0", ResultSrc, IRWrite, PCWrite); end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype;
    obs_t o;
    for (int k = 0; k < 2; k++) begin
      run_instr(OP_R, 3'b000, 1'(k), 0, 0, 1'b0, o);
      tests++; if (o.alu_exec != k) begin fails++; $display("[TB] FAIL rtype%0d_alu got %0d want %0d", k, o.alu_exec, k); end
      tests++; if (o.rw_cnt != 1 || o.rw_cycle != 4) begin fails++;
        $display("[TB] FAIL rtype%0d_regwrite got cnt=%0d cyc=%0d want 1 4", k, o.rw_cnt, o.rw_cycle); end
      tests++; if (o.rs_after != 2) begin fails++; $display("[TB] FAIL rtype%0d_refetch got rs=%0d want 2", k, o.rs_after); end
    end
  endtask

  task automatic test_lw_waits;
    obs_t o;
    run_instr(OP_LW, 3'b010, 1'b0, 2, 3, 1'b0, o);
    tests++; if (o.irw_cnt != 1 || o.irw_cycle != 3) begin fails++;
      $display("[TB] FAIL lw_irwrite got cnt=%0d cyc=%0d want 1 3", o.irw_cnt, o.irw_cycle); end
    tests++; if (o.rw_cnt != 1 || o.rw_cycle != 10 || o.rs_last != 1) begin fails++;
      $display("[TB] FAIL lw_memwb got cnt=%0d cyc=%0d rs=%0d want 1 10 1", o.rw_cnt, o.rw_cycle, o.rs_last); end
    tests++; if (o.rs_after != 2 || o.early_fetch != 0) begin fails++;
      $display("[TB] FAIL lw_latency got after=%0d early=%0d want 2 0", o.rs_after, o.early_fetch); end
  endtask

  task automatic test_beq;
    obs_t o;
    for (int z = 1; z >= 0; z--) begin
      run_instr(OP_BEQ, 3'b000, 1'b0, 0, 0, 1'(z), o);
      tests++; if (o.pcw_exec != z || o.alu_exec != 1) begin fails++;
        $display("[TB] FAIL beq_z%0d got pcw=%0d alu=%0d want %0d 1", z, o.pcw_exec, o.alu_exec, z); end
      tests++; if (o.rs_after != 2 || o.early_fetch != 0 || o.rw_cnt != 0) begin fails++;
        $display("[TB] FAIL beq_z%0d_latency got after=%0d early=%0d rw=%0d want 2 0 0", z, o.rs_after, o.early_fetch, o.rw_cnt); end
    end
  endtask

  task automatic test_sw_waits;
    obs_t o;
    run_instr(OP_SW, 3'b010, 1'b0, 0, 4, 1'b0, o);
    tests++; if (o.mw_cnt != 5 || o.mw_noadr != 0) begin fails++;
      $display("[TB] FAIL sw_memwrite got cnt=%0d noadr=%0d want 5 0", o.mw_cnt, o.mw_noadr); end
    tests++; if (o.rs_after != 2 || o.rw_cnt != 0) begin fails++;
      $display("[TB] FAIL sw_return got after=%0d rw=%0d want 2 0", o.rs_after, o.rw_cnt); end
  endtask

  task automatic test_trap;
    int bad;
    for (int k = 0; k < 2; k++) begin
      op = (k == 0) ? 7'b1111111 : OP_R;
      funct3 = (k == 0) ? 3'($urandom_range(0, 7)) : 3'b001;
      funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;
      @(negedge clk);
      tests++; if (Illegal !== 1'b0) begin fails++; $display("[TB] FAIL trap%0d_pre got %b want 0", k, Illegal); end
      @(posedge clk); #1;
      @(negedge clk); @(posedge clk); #1;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
        MemReady = 1'($urandom_range(0, 1)); Zero = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (PCWrite || MemWrite || IRWrite || RegWrite || !Illegal) bad++;
        @(posedge clk); #1;
      end
      tests++; if (bad != 0) begin fails++; $display("[TB] FAIL trap%0d_hold got %0d bad cycles want 0", k, bad); end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; MemReady = 1'b0;
      @(negedge clk);
      tests++; if (Illegal !== 1'b0 || ResultSrc !== 2'b10) begin fails++;
        $display("[TB] FAIL trap%0d_recover got ill=%b rs=%b want 0 10", k, Illegal, ResultSrc); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_write;
    obs_t o;
    op = OP_SW; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk); @(posedge clk); #1;
    MemReady = 1'($urandom_range(0, 1));
    @(negedge clk); @(posedge clk); #1;
    MemReady = 1'b0;
    @(negedge clk);
    tests++; if (MemWrite !== 1'b1) begin fails++; $display("[TB] FAIL midwr_wait got mw=%b want 1", MemWrite); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    tests++; if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b0000) begin fails++;
      $display("[TB] FAIL midwr_reset got %b want 0000", {PCWrite, MemWrite, IRWrite, RegWrite}); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    tests++; if (ResultSrc !== 2'b10 || MemWrite !== 1'b0) begin fails++;
      $display("[TB] FAIL midwr_fetch got rs=%b mw=%b want 10 0", ResultSrc, MemWrite); end
    @(posedge clk); #1;
    run_instr(OP_I, 3'b010, 1'b0, 0, 0, 1'b0, o);
    tests++; if (o.alu_exec != 4 || o.rw_cycle != 4) begin fails++;
      $display("[TB] FAIL midwr_slti got alu=%0d rwcyc=%0d want 4 4", o.alu_exec, o.rw_cycle); end
  endtask

  task automatic test_random;
    obs_t o;
    logic [6:0] iop;
    logic [2:0] if3;
    logic if7, zb;
    int fw, mw, len, exp_pcw, exp_rw, exp_mw;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: iop = OP_LW; 1: iop = OP_SW; 2: iop = OP_R;
        3: iop = OP_I;  4: iop = OP_BEQ; default: iop = OP_JAL;
      endcase
      if3 = 3'($urandom_range(0, 7));
      if (iop == OP_R || iop == OP_I)
        case ($urandom_range(0, 3))
          0: if3 = 3'b000; 1: if3 = 3'b010; 2: if3 = 3'b110; default: if3 = 3'b111;
        endcase
      if7 = 1'($urandom_range(0, 1)); zb = 1'($urandom_range(0, 1));
      fw = $urandom_range(0, 3); mw = $urandom_range(0, 3);
      if (iop != OP_LW && iop != OP_SW) mw = 0;
      len = model_len(iop, fw, mw);
      exp_pcw = 1 + ((iop == OP_JAL) ? 1 : 0) + ((iop == OP_BEQ && zb) ? 1 : 0);
      exp_rw  = (iop == OP_SW || iop == OP_BEQ) ? 0 : 1;
      exp_mw  = (iop == OP_SW) ? mw + 1 : 0;
      run_instr(iop, if3, if7, fw, mw, zb, o);
      tests++; if (o.irw_cnt != 1 || o.irw_cycle != fw + 1) begin fails++;
        $display("[TB] FAIL rand%0d_irwrite op=%b got cnt=%0d cyc=%0d want 1 %0d", i, iop, o.irw_cnt, o.irw_cycle, fw + 1); end
      tests++; if (o.pcw_cnt != exp_pcw) begin fails++;
        $display("[TB] FAIL rand%0d_pcwrite op=%b got %0d want %0d", i, iop, o.pcw_cnt, exp_pcw); end
      tests++; if (o.rw_cnt != exp_rw || (exp_rw == 1 && o.rw_cycle != len)) begin fails++;
        $display("[TB] FAIL rand%0d_regwrite op=%b got cnt=%0d cyc=%0d want %0d %0d", i, iop, o.rw_cnt, o.rw_cycle, exp_rw, len); end
      tests++; if (o.mw_cnt != exp_mw || o.mw_noadr != 0) begin fails++;
        $display("[TB] FAIL rand%0d_memwrite op=%b got cnt=%0d noadr=%0d want %0d 0", i, iop, o.mw_cnt, o.mw_noadr, exp_mw); end
      tests++; if (o.alu_exec != model_alu(iop, if3, if7)) begin fails++;
        $display("[TB] FAIL rand%0d_alu op=%b f3=%b got %0d want %0d", i, iop, if3, o.alu_exec, model_alu(iop, if3, if7)); end
      tests++; if (o.rs_after != 2 || o.early_fetch != 0) begin fails++;
        $display("[TB] FAIL rand%0d_latency op=%b got after=%0d early=%0d want 2 0", i, iop, o.rs_after, o.early_fetch); end
      tests++; if (o.imm_bad != 0) begin fails++;
        $display("[TB] FAIL rand%0d_immsrc op=%b got %0d bad cycles want 0", i, iop, o.imm_bad); end
      tests++; if (iop == OP_LW && o.rs_last != 1) begin fails++;
        $display("[TB] FAIL rand%0d_lw_result got rs=%0d want 1", i, o.rs_last); end
    end
  endtask

  initial begin
    reset = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b0;
    test_reset();
    test_rtype();
    test_lw_waits();
    test_beq();
    test_sw_waits();
    test_trap();
    test_reset_mid_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RISC-V datapath variant.
- Produces the ALUControl code consumed by the ALU, plus register/memory/PC enables and datapath mux selects, from the opcode/funct fields and the ALU Zero flag.
- One unified memory is shared by instruction and data accesses, with a ready handshake.
- Supported instructions: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal.

Parameters:
- XLEN, 32: datapath width; documentation only, no port depends on it.

Ports:
- clk  in  1: rising-edge clock.
- reset  in  1: synchronous, active-high.
- op  in  7: instr[6:0].
- funct3  in  3: instr[14:12].
- funct7b5  in  1: instr[30].
- Zero  in  1: ALU zero flag.
- MemReady  in  1: memory has completed the current access this cycle.
- PCWrite  out  1: PC register enable.
- AdrSrc  out  1: memory address select; 0=PC, 1=ALUOut.
- MemWrite  out  1: memory write strobe.
- IRWrite  out  1: instruction/OldPC register enable.
- ResultSrc  out  2: result select; 00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  out  2: ALU A select; 00 PC, 01 OldPC, 10 RD1.
- ALUSrcB  out  2: ALU B select; 00 RD2, 01 ImmExt, 10 constant 4.
- ImmSrc  out  2: immediate format; 00 I, 01 S, 10 B, 11 J.
- RegWrite  out  1: register file write enable.
- ALUControl  out  3: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT.
- Illegal  out  1: sticky unsupported-instruction flag.

Behaviour:
- Clocking/reset: single clock domain. reset is synchronous, active-high, sampled on the rising edge of clk.
  - Reset forces state to FETCH and clears Illegal.
  - While reset=1, PCWrite, MemWrite, IRWrite and RegWrite are forced to 0. Other outputs are don't-care but take their FETCH values.
- Outputs: Moore-decoded from state, except three qualified terms:
  - PCWrite = PCUpdate | (Branch & Zero).
  - IRWrite and the FETCH PCUpdate are qualified by MemReady.
- ALUOp (internal): 00 → ADD; 01 → SUB; 10 → funct decode:
  - funct3 000 → SUB if (op[5] & funct7b5), else ADD.
  - funct3 010 → SLT; 110 → OR; 111 → AND.
  - Any other funct3 → the instruction is illegal.
- States and asserted outputs (unlisted outputs are 0):
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCUpdate=MemReady. Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch target).
    - lw/sw → MEMADR; R → EXECUTER; I-ALU → EXECUTEI; jal → JAL; beq → BEQ.
    - Any other op, or illegal funct3 for R/I → TRAP.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw → MEMREAD; sw → MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Holds until MemReady, then → MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 (held high while waiting). Holds until MemReady, then → FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 → ALUWB.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 → FETCH.
  - TRAP: all enables 0, Illegal=1. Absorbing; exits only on reset.
- ImmSrc is decoded from op in every state:
  - lw/I-ALU → 00; sw → 01; beq → 10; jal → 11; otherwise 00.
- Latency with MemReady=1 throughout, counted FETCH through the final state:
  - beq: 3 cycles.
  - R/I/sw/jal: 4 cycles.
  - lw: 5 cycles.
- Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Boundary conditions:
  - Reset mid-instruction (any state, including a MEMWRITE wait) → FETCH on the next edge. No partial write enable appears in the reset cycle.
  - MemReady high in non-memory states is ignored.
  - Unknown or X state recovers to FETCH.

Decomposition:
- riscv_pkg holds:
  - Opcode constants: OP_LW 0000011, OP_SW 0100011, OP_R 0110011, OP_I 0010011, OP_BEQ 1100011, OP_JAL 1101111.
  - alu_ctrl_e enum (0–4, shared with the ALU).
  - alu_op_e enum.
  - ctrl_state_e enum.
- One combinational sub-module, alu_decoder: (ALUOp, funct3, op[5], funct7b5) → (ALUControl, funct_illegal).

Test Plan:
- add x3,x1,x2 (op=0110011, f3=000, f7b5=0), MemReady=1 → states FETCH,DECODE,EXECUTER,ALUWB. ALUControl=0 in EXECUTER; RegWrite=1 only in cycle 4. Same with f7b5=1 → ALUControl=1.
- lw, MemReady low for 2 cycles in FETCH and 3 cycles in MEMREAD → IRWrite pulses exactly once. MEMWB (RegWrite=1, ResultSrc=01) occurs at cycle 10.
- beq, Zero=1 in BEQ → PCWrite=1, ALUControl=1. Repeat with Zero=0 → PCWrite=0. Both return to FETCH after 3 cycles.
- sw with MemReady=0 for 4 cycles in MEMWRITE → MemWrite high for 5 consecutive cycles, AdrSrc=1, then FETCH.
- op=1111111, then funct3=001 on an R-type → TRAP, Illegal=1, all enables 0 for 20 cycles. reset=1 for one edge → FETCH, Illegal=0.
- reset asserted during the MEMWRITE wait → MemWrite=0 in the reset cycle. Next state is FETCH; slti (f3=010) then yields ALUControl=4 in EXECUTEI.
